lfsr_seq_ctrl: RTL and testbench

- Sequencer that owns one `lfsr` instance and turns it into a command-driven word source.
- Accepts a start command (seed, word count) and loads the seed into the LFSR.
- Streams exactly `count` LFSR states over a valid/ready interface, then pulses done.
- Also reports period wrap-around and rejects the XNOR lock-up seed. It sits between test/crypto stimulus logic and any consumer of pseudo-random words.

---
 rtl/lfsr_seq_ctrl_pkg.sv | 29 ++
 rtl/lfsr.sv | 82 ++++++++
 rtl/lfsr_seq_ctrl.sv | 154 +++++++++++++++
 tb/tb_lfsr_seq_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_seq_ctrl_pkg.sv
// ============================================================================
// Module      : lfsr_seq_ctrl_pkg
// Description : Shared types and helpers for the LFSR sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lfsr_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  // All-ones value of width n: the state an XNOR LFSR can never leave.
  function automatic logic [31:0] lockup_seed(input int unsigned n);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < n) v[i] = 1'b1;
    end
    return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lfsr.sv
// ============================================================================
// Module      : lfsr
// Description : Fibonacci XNOR LFSR (3..32 bits) with seed load and a
//               seed-match flag. The state register has no reset; it is
//               always seeded before use.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lfsr #(
  parameter int NUM_BITS = 5
) (
  input  logic                clk,
  input  logic                enable,
  input  logic                seed_dv,
  input  logic [NUM_BITS-1:0] Seed_Data,
  output logic [NUM_BITS-1:0] LFSR_Data,
  output logic                LFSR_Done
);

  // Feedback tap positions (bit i-1 set for tap i) of maximal-length XNOR
  // polynomials. Every entry has an even tap count, so the XNOR chain reduces
  // to the inverted parity of the tapped bits.
  function automatic logic [31:0] tap_mask(input int unsigned n);
    logic [31:0] m;
    case (n)
      3:       m = 32'h0000_0006;
      4:       m = 32'h0000_000C;
      5:       m = 32'h0000_0014;
      6:       m = 32'h0000_0030;
      7:       m = 32'h0000_0060;
      8:       m = 32'h0000_00B8;
      9:       m = 32'h0000_0110;
      10:      m = 32'h0000_0240;
      11:      m = 32'h0000_0500;
      12:      m = 32'h0000_0829;
      13:      m = 32'h0000_100D;
      14:      m = 32'h0000_2015;
      15:      m = 32'h0000_6000;
      16:      m = 32'h0000_D008;
      17:      m = 32'h0001_2000;
      18:      m = 32'h0002_0400;
      19:      m = 32'h0004_0023;
      20:      m = 32'h0009_0000;
      21:      m = 32'h0014_0000;
      22:      m = 32'h0030_0000;
      23:      m = 32'h0042_0000;
      24:      m = 32'h00E1_0000;
      25:      m = 32'h0120_0000;
      26:      m = 32'h0200_0023;
      27:      m = 32'h0400_0013;
      28:      m = 32'h0900_0000;
      29:      m = 32'h1400_0000;
      30:      m = 32'h2000_0029;
      31:      m = 32'h4800_0000;
      32:      m = 32'h8020_0003;
      default: m = 32'h0000_0000;
    endcase
    return m;
  endfunction

  localparam logic [31:0]         TAPS_FULL = tap_mask(NUM_BITS);
  localparam logic [NUM_BITS-1:0] TAPS      = TAPS_FULL[NUM_BITS-1:0];

  logic [NUM_BITS-1:0] state;
  logic                feedback;

  assign feedback  = ~(^(state & TAPS));
  assign LFSR_Data = state;
  assign LFSR_Done = (state == Seed_Data);

  // Load the seed or advance one step whenever enabled.
  always_ff @(posedge clk) begin
    if (enable) begin
      if (seed_dv) state <= Seed_Data;
      else         state <= {state[NUM_BITS-2:0], feedback};
    end
  end

endmodule

`default_nettype wire

// File: rtl/lfsr_seq_ctrl.sv
// ============================================================================
// Module      : lfsr_seq_ctrl
// Description : Command-driven word source around one lfsr instance. A start
//               command loads a seed and streams `count` LFSR states over a
//               valid/ready port, then pulses done. Flags period wrap and
//               rejects the all-ones lock-up seed.
//               Optional macro LFSR_SEQ_CTRL_PERIOD_EN builds the period
//               measurement; otherwise period is tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lfsr_seq_ctrl
  import lfsr_seq_ctrl_pkg::*;
#(
  parameter int NUM_BITS = 5,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [NUM_BITS-1:0] seed,
  input  logic [CNT_W-1:0]    count,
  output logic                busy,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [NUM_BITS-1:0] out_data,
  output logic                done,
  output logic                err,
  output logic                wrapped,
  output logic [CNT_W-1:0]    period
);

  localparam logic [31:0]         LOCKUP_FULL = lockup_seed(NUM_BITS);
  localparam logic [NUM_BITS-1:0] LOCKUP      = LOCKUP_FULL[NUM_BITS-1:0];

  state_t              state_q;
  state_t              state_d;
  logic [NUM_BITS-1:0] seed_q;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    idx;
  logic                err_q;
  logic                wrapped_q;

  logic                lfsr_en;
  logic                lfsr_load;
  logic [NUM_BITS-1:0] lfsr_data;
  logic                lfsr_done;

  logic                xfer;
  logic                accept;
  logic                reject;
  logic                wrap_hit;

  assign xfer     = (state_q == RUN) && out_ready;
  assign accept   = (state_q == IDLE) && start && (seed != LOCKUP);
  assign reject   = (state_q == IDLE) && start && (seed == LOCKUP);
  // idx>0 excludes the seed word itself, which trivially matches seed_q.
  assign wrap_hit = (state_q == RUN) && (idx != '0) && lfsr_done;

  lfsr #(
    .NUM_BITS (NUM_BITS)
  ) u_lfsr (
    .clk       (clk),
    .enable    (lfsr_en),
    .seed_dv   (lfsr_load),
    .Seed_Data (seed_q),
    .LFSR_Data (lfsr_data),
    .LFSR_Done (lfsr_done)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) state_d = (count == '0) ? DONE : LOAD;
      end
      LOAD:    state_d = RUN;
      RUN: begin
        if (xfer && (cnt == CNT_W'(1))) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Moore outputs and LFSR control; the LFSR only moves on load or transfer,
  // which keeps out_data stable through stalls.
  always_comb begin
    busy      = (state_q != IDLE);
    out_valid = (state_q == RUN);
    done      = (state_q == DONE);
    lfsr_en   = (state_q == LOAD) || xfer;
    lfsr_load = (state_q == LOAD);
  end

  assign out_data = lfsr_data;
  assign err      = err_q;
  assign wrapped  = wrapped_q;

  // Command capture, word counters, reject pulse and sticky wrap flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seed_q    <= '0;
      cnt       <= '0;
      idx       <= '0;
      err_q     <= 1'b0;
      wrapped_q <= 1'b0;
    end else begin
      err_q <= reject;
      if (accept) begin
        seed_q    <= seed;
        cnt       <= count;
        idx       <= '0;
        wrapped_q <= 1'b0;
      end else begin
        if (xfer) begin
          cnt <= cnt - CNT_W'(1);
          idx <= idx + CNT_W'(1);
        end
        if (wrap_hit) wrapped_q <= 1'b1;
      end
    end
  end

`ifdef LFSR_SEQ_CTRL_PERIOD_EN
  logic [CNT_W-1:0] period_q;

  // Latch the step count at the first wrap of a run only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      period_q <= '0;
    end else if (accept) begin
      period_q <= '0;
    end else if (wrap_hit && !wrapped_q) begin
      period_q <= idx;
    end
  end

  assign period = period_q;
`else
  assign period = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_lfsr_seq_ctrl.sv
// ============================================================================
// Module      : tb_lfsr_seq_ctrl
// Description : Scoreboard bench for lfsr_seq_ctrl (NUM_BITS=5, CNT_W=16).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lfsr_seq_ctrl;

  localparam int NB = 5;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [NB-1:0] seed;
  logic [CW-1:0] count;
  logic          busy;
  logic          out_valid;
  logic          out_ready;
  logic [NB-1:0] out_data;
  logic          done;
  logic          err;
  logic          wrapped;
  logic [CW-1:0] period;

  lfsr_seq_ctrl #(
    .NUM_BITS (NB),
    .CNT_W    (CW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .seed      (seed),
    .count     (count),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .done      (done),
    .err       (err),
    .wrapped   (wrapped),
    .period    (period)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          wrapped;
    logic [CW-1:0] period;
    bit            has_words;
  } done_exp_t;

  int            checks = 0;
  int            failures = 0;
  int            cyc = 0;
  logic [NB-1:0] exp_q[$];
  done_exp_t     done_q[$];
  int            err_exp = 0;
  int            done_cnt = 0;
  int            xfer_cnt = 0;
  int            done_cyc = 0;
  int            last_xfer_cyc = 0;
  logic          last_wrapped = 1'b0;
  int            ready_mode = 0;
  int            phase = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Reference step: shift left, new LSB = XNOR of taps 5 and 3 (bits 4 and 2).
  function automatic logic [NB-1:0] lfsr_next(input logic [NB-1:0] s);
    int v;
    int fb;
    v  = int'(s);
    fb = (((v >> 4) & 1) == ((v >> 2) & 1)) ? 1 : 0;
    return NB'(((v << 1) | fb) & 31);
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Consumer ready: always, fixed toggle pattern, or random.
  initial begin
    bit pat[7];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1: begin
          out_ready = pat[phase % 7];
          phase++;
        end
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: pops expectations whenever the DUT presents a word, done or err.
  initial begin
    logic          stall_prev;
    logic [NB-1:0] stall_data;
    logic [NB-1:0] e;
    done_exp_t     d;
    stall_prev = 1'b0;
    stall_data = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          check("stall_valid_hold", 32'(out_valid), 32'd1);
          check("stall_data_hold", 32'(out_data), 32'(stall_data));
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_word", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("word", 32'(out_data), 32'(e));
          end
          xfer_cnt++;
          last_xfer_cyc = cyc;
        end
        stall_prev = out_valid && !out_ready;
        stall_data = out_data;
        if (done) begin
          if (done_q.size() == 0) begin
            check("unexpected_done", 32'd1, 32'd0);
          end else begin
            d = done_q.pop_front();
            check("done_words_left", 32'(exp_q.size()), 32'd0);
            check("done_wrapped", 32'(wrapped), 32'(d.wrapped));
            check("done_period", 32'(period), 32'(d.period));
            check("done_busy", 32'(busy), 32'd1);
            check("done_valid", 32'(out_valid), 32'd0);
            if (d.has_words) check("done_latency", 32'(cyc - last_xfer_cyc), 32'd1);
          end
          done_cnt++;
          done_cyc = cyc;
        end
        if (err) begin
          if (err_exp == 0) check("unexpected_err", 32'd1, 32'd0);
          else err_exp--;
        end
      end
    end
  end

  task automatic push_model(input logic [NB-1:0] s, input int n, output logic wr);
    logic [NB-1:0] w;
    int            per;
    done_exp_t     de;
    w   = s;
    wr  = 1'b0;
    per = 0;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(w);
      if (i > 0 && w == s && !wr) begin
        wr  = 1'b1;
        per = i;
      end
      w = lfsr_next(w);
    end
`ifndef LFSR_SEQ_CTRL_PERIOD_EN
    per = 0;
`endif
    de.wrapped   = wr;
    de.period    = CW'(per);
    de.has_words = (n > 0);
    done_q.push_back(de);
  endtask

  task automatic run_cmd(input logic [NB-1:0] s, input int n, input int mode, input bit poke);
    int   d0;
    int   budget;
    int   load_cyc;
    logic wr;
    check("idle_wrapped_hold", 32'(wrapped), 32'(last_wrapped));
    ready_mode = mode;
    phase      = 0;
    push_model(s, n, wr);
    d0    = done_cnt;
    start = 1'b1;
    seed  = s;
    count = CW'(n);
    @(posedge clk);
    #1;
    start = 1'b0;
    seed  = NB'($urandom);
    count = CW'($urandom);
    @(negedge clk);
    load_cyc = cyc;
    check("cmd_busy", 32'(busy), 32'd1);
    check("cmd_no_valid", 32'(out_valid), 32'd0);
    check("cmd_wrapped_clear", 32'(wrapped), 32'd0);
    check("cmd_period_clear", 32'(period), 32'd0);
    if (n > 0) begin
      @(negedge clk);
      check("first_valid", 32'(out_valid), 32'd1);
      check("first_word", 32'(out_data), 32'(s));
    end
    budget = 0;
    while (done_cnt == d0 && budget < 3000) begin
      @(posedge clk);
      #1;
      budget++;
      if (poke && budget == 3) begin
        start = 1'b1; seed = NB'(5); count = CW'(2);
      end else if (poke && budget == 5) begin
        start = 1'b1; seed = '1; count = CW'(7);
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check("done_seen", 32'(done_cnt - d0), 32'd1);
    if (mode == 0 && n > 0) check("run_cycles", 32'(done_cyc - load_cyc), 32'(n + 1));
    last_wrapped = wr;
    @(negedge clk);
    check("post_idle_busy", 32'(busy), 32'd0);
    check("post_wrapped_hold", 32'(wrapped), 32'(wr));
  endtask

  task automatic reject_cmd();
    err_exp = 1;
    start   = 1'b1;
    seed    = '1;
    count   = CW'(5);
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    check("err_pulse", 32'(err), 32'd1);
    check("err_busy", 32'(busy), 32'd0);
    check("err_valid", 32'(out_valid), 32'd0);
    check("err_wrapped_hold", 32'(wrapped), 32'(last_wrapped));
    @(negedge clk);
    check("err_one_cycle", 32'(err), 32'd0);
    check("err_busy_after", 32'(busy), 32'd0);
    err_exp = 0;
  endtask

  task automatic reset_mid_run();
    int   x0;
    int   b;
    logic wr;
    ready_mode = 0;
    push_model(NB'($urandom_range(0, 30)), 10, wr);
    x0    = xfer_cnt;
    start = 1'b1;
    seed  = exp_q[0];
    count = CW'(10);
    @(posedge clk);
    #1;
    start = 1'b0;
    b = 0;
    while (xfer_cnt - x0 < 2 && b < 50) begin
      @(negedge clk);
      b++;
    end
    check("reset_run_reached", 32'(xfer_cnt - x0), 32'd2);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_wrapped", 32'(wrapped), 32'd0);
    exp_q.delete();
    done_q.delete();
    @(posedge clk);
    #1;
    reset        = 1'b0;
    last_wrapped = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    seed  = '0;
    count = '0;
    #2;
    check("rst_state_busy", 32'(busy), 32'd0);
    check("rst_state_valid", 32'(out_valid), 32'd0);
    check("rst_state_done", 32'(done), 32'd0);
    check("rst_state_err", 32'(err), 32'd0);
    check("rst_state_wrapped", 32'(wrapped), 32'd0);
    check("rst_state_period", 32'(period), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);

    run_cmd(NB'(0), 4, 0, 1'b0);
    run_cmd(NB'(0), 4, 1, 1'b0);
    run_cmd(NB'(0), 32, 0, 1'b0);
    reject_cmd();
    run_cmd(NB'(0), 0, 0, 1'b0);
    run_cmd(NB'($urandom_range(0, 30)), 12, 2, 1'b1);
    reset_mid_run();
    run_cmd(NB'($urandom_range(0, 30)), 6, 0, 1'b0);
    run_cmd(NB'(7), 70, 2, 1'b0);
    for (int i = 0; i < 8; i++) begin
      run_cmd(NB'($urandom_range(0, 30)), int'($urandom_range(0, 40)),
              int'($urandom_range(0, 2)), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
